// File: rtl/rx_lane_controller.sv
// rtl/rx_lane_controller.sv - Aurora RX lane controller: ordered-set decode, lock FSM, word reassembly
// Define RX_LANE_CTRL_STATS_EN to add o_err_count, a saturating count of frame_err strobes.
package rx_lane_controller_pkg;
  typedef enum logic [2:0] {
    OS_NONE,
    OS_IDLE,
    OS_CLOCK_COMP,
    OS_CHANNEL_BOND,
    OS_VERIFY
  } ordered_sets_e;
endpackage

module rx_lane_controller
  import rx_lane_controller_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int LANE_SEL_W  = 2,
  parameter int BYTE_W      = 8,
  parameter int DATA_W      = 32,
  parameter int LOCK_IDLES  = 4,
  parameter int UNLOCK_ERRS = 3
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_single_lane,
  input  logic [LANE_SEL_W-1:0]             i_lane_select,
  input  logic [LANES-1:0]                  i_ctrl_in,
  input  logic [LANES-1:0][BYTE_W-1:0]      i_data_in,
  output logic [DATA_W-1:0]                 o_data_out,
  output logic                              o_data_valid,
  output ordered_sets_e                     o_ordered_sets,
  output logic                              o_locked,
`ifdef RX_LANE_CTRL_STATS_EN
  output logic [15:0]                       o_err_count,
`endif
  output logic                              o_frame_err
);

  localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int IDLE_W = $clog2(LOCK_IDLES + 1);
  localparam int ERR_W  = $clog2(UNLOCK_ERRS + 1);
  localparam int ACC_W  = DATA_W - BYTE_W;

  localparam logic [BYTE_W-1:0] K_IDLE = BYTE_W'(8'hBC);
  localparam logic [BYTE_W-1:0] K_CC   = BYTE_W'(8'h1C);
  localparam logic [BYTE_W-1:0] K_CB   = BYTE_W'(8'h7C);
  localparam logic [BYTE_W-1:0] K_VER  = BYTE_W'(8'hFB);

  typedef enum logic [1:0] {CL_DATA, CL_CONTROL, CL_INVALID} class_e;
  typedef enum logic {ST_HUNT, ST_LOCKED} state_e;

  state_e              r_state;
  logic                r_locked;
  logic [IDLE_W-1:0]   r_idle_cnt;
  logic [ERR_W-1:0]    r_err_run;
  logic [IDX_W-1:0]    r_idx;
  logic [ACC_W-1:0]    r_acc;
  logic                r_single_lane;
  logic [LANE_SEL_W-1:0] r_lane_select;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_data_valid;
  ordered_sets_e       r_ordered_sets;
  logic                r_frame_err;

  logic                w_k_match;
  logic                w_all_k;
  logic                w_no_k;
  logic [BYTE_W-1:0]   w_ref_byte;
  ordered_sets_e       w_code;
  class_e              w_class;
  logic [DATA_W-1:0]   w_lane_word;
  logic                w_mode_chg;
  logic [IDX_W-1:0]    w_idx;
  logic [DATA_W-1:0]   w_acc_next;
  logic                w_frame_err;

  // Classification only looks at the lanes in use; in multi-lane mode all K bytes must agree.
  always_comb begin
    w_k_match = 1'b1;
    for (int i = 1; i < LANES; i++) begin
      if (i_data_in[i] != i_data_in[0]) w_k_match = 1'b0;
    end
    w_ref_byte = i_single_lane ? i_data_in[i_lane_select] : i_data_in[0];
    w_all_k    = i_single_lane ? i_ctrl_in[i_lane_select] : ((&i_ctrl_in) && w_k_match);
    w_no_k     = i_single_lane ? ~i_ctrl_in[i_lane_select] : ~(|i_ctrl_in);
    case (w_ref_byte)
      K_IDLE:  w_code = OS_IDLE;
      K_CC:    w_code = OS_CLOCK_COMP;
      K_CB:    w_code = OS_CHANNEL_BOND;
      K_VER:   w_code = OS_VERIFY;
      default: w_code = OS_NONE;
    endcase
    if (w_no_k)                             w_class = CL_DATA;
    else if (w_all_k && w_code != OS_NONE)  w_class = CL_CONTROL;
    else                                    w_class = CL_INVALID;
  end

  always_comb begin
    w_lane_word = '0;
    for (int i = 0; i < LANES; i++) begin
      w_lane_word[DATA_W-1-i*BYTE_W -: BYTE_W] = i_data_in[i];
    end
  end

  // A lane-mode change restarts reassembly in the same cycle the new mode is seen.
  assign w_mode_chg = (i_single_lane != r_single_lane) || (i_lane_select != r_lane_select);
  assign w_idx      = w_mode_chg ? '0 : r_idx;
  assign w_acc_next = {(w_mode_chg ? {ACC_W{1'b0}} : r_acc), w_ref_byte};

  assign w_frame_err = (w_class == CL_INVALID) ||
                       ((r_state == ST_LOCKED) && i_single_lane && (w_class == CL_CONTROL) &&
                        (w_code != OS_CLOCK_COMP) && (w_idx != '0));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= ST_HUNT;
      r_locked       <= 1'b0;
      r_idle_cnt     <= '0;
      r_err_run      <= '0;
      r_idx          <= '0;
      r_acc          <= '0;
      r_single_lane  <= 1'b0;
      r_lane_select  <= '0;
      r_data_out     <= '0;
      r_data_valid   <= 1'b0;
      r_ordered_sets <= OS_NONE;
      r_frame_err    <= 1'b0;
    end else begin
      r_single_lane  <= i_single_lane;
      r_lane_select  <= i_lane_select;
      r_data_valid   <= 1'b0;
      r_frame_err    <= w_frame_err;
      r_ordered_sets <= (w_class == CL_CONTROL) ? w_code : OS_NONE;
      r_idx          <= w_idx;
      r_acc          <= w_mode_chg ? '0 : r_acc;
      case (r_state)
        ST_HUNT: begin
          r_idx <= '0;
          r_acc <= '0;
          if (w_class == CL_CONTROL && w_code == OS_IDLE) begin
            if (r_idle_cnt == IDLE_W'(LOCK_IDLES - 1)) begin
              r_state    <= ST_LOCKED;
              r_locked   <= 1'b1;
              r_idle_cnt <= '0;
            end else begin
              r_idle_cnt <= r_idle_cnt + 1'b1;
            end
          end else begin
            r_idle_cnt <= '0;
          end
        end
        ST_LOCKED: begin
          if (w_class == CL_INVALID) begin
            r_idx <= '0;
            r_acc <= '0;
            if (r_err_run == ERR_W'(UNLOCK_ERRS - 1)) begin
              r_state    <= ST_HUNT;
              r_locked   <= 1'b0;
              r_err_run  <= '0;
              r_idle_cnt <= '0;
            end else begin
              r_err_run <= r_err_run + 1'b1;
            end
          end else begin
            r_err_run <= '0;
            if (w_class == CL_DATA) begin
              if (!i_single_lane) begin
                r_data_out   <= w_lane_word;
                r_data_valid <= 1'b1;
              end else if (w_idx == IDX_W'(LANES - 1)) begin
                r_data_out   <= w_acc_next;
                r_data_valid <= 1'b1;
                r_idx        <= '0;
                r_acc        <= '0;
              end else begin
                r_idx <= w_idx + 1'b1;
                r_acc <= w_acc_next[ACC_W-1:0];
              end
            end else if (w_code != OS_CLOCK_COMP) begin
              r_idx <= '0;
              r_acc <= '0;
            end
          end
        end
        default: r_state <= ST_HUNT;
      endcase
    end
  end

`ifdef RX_LANE_CTRL_STATS_EN
  logic [15:0] r_err_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_err_count <= '0;
    end else if (w_frame_err && r_err_count != 16'hFFFF) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign o_err_count = r_err_count;
`endif

  assign o_data_out     = r_data_out;
  assign o_data_valid   = r_data_valid;
  assign o_ordered_sets = r_ordered_sets;
  assign o_locked       = r_locked;
  assign o_frame_err    = r_frame_err;

endmodule

// File: tb/tb_rx_lane_controller.sv
// tb/tb_rx_lane_controller.sv - directed-vector bench for rx_lane_controller
module tb_rx_lane_controller;
  import rx_lane_controller_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 single_lane;
  logic [1:0]           lane_select;
  logic [3:0]           ctrl_in;
  logic [3:0][7:0]      data_in;
  logic [31:0]          data_out;
  logic                 data_valid;
  ordered_sets_e        ordered_sets;
  logic                 locked;
  logic                 frame_err;
`ifdef RX_LANE_CTRL_STATS_EN
  logic [15:0]          err_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rx_lane_controller dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_single_lane  (single_lane),
    .i_lane_select  (lane_select),
    .i_ctrl_in      (ctrl_in),
    .i_data_in      (data_in),
    .o_data_out     (data_out),
    .o_data_valid   (data_valid),
    .o_ordered_sets (ordered_sets),
    .o_locked       (locked),
`ifdef RX_LANE_CTRL_STATS_EN
    .o_err_count    (err_count),
`endif
    .o_frame_err    (frame_err)
  );

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle: word b carries lane 0 in its MSB byte.
  task automatic step(input logic [3:0] c, input logic [31:0] b);
    ctrl_in = c;
    for (int i = 0; i < 4; i++) data_in[i] = b[31-8*i -: 8];
    tick();
  endtask

  // Single-lane byte on lane 2 with random traffic on the ignored lanes.
  task automatic sl(input logic k, input logic [7:0] b);
    logic [31:0] d;
    logic [3:0]  c;
    d       = $urandom;
    d[15:8] = b;
    c       = 4'($urandom);
    c[2]    = k;
    step(c, d);
  endtask

  task automatic chk_out(input string tag, input logic exp_valid, input logic [31:0] exp_data,
                         input logic exp_fe);
    check_vec({tag, "_valid"}, 32'(data_valid), 32'(exp_valid));
    if (exp_valid) check_vec({tag, "_data"}, data_out, exp_data);
    check_vec({tag, "_ferr"}, 32'(frame_err), 32'(exp_fe));
  endtask

  initial begin
    rst_n       = 1'b0;
    single_lane = 1'b0;
    lane_select = 2'd0;
    ctrl_in     = 4'h0;
    data_in     = '0;
    tick();
    tick();
    check_vec("rst_data_out", data_out, 32'h0);
    check_vec("rst_valid", 32'(data_valid), 32'h0);
    check_vec("rst_os", 32'(ordered_sets), 32'(OS_NONE));
    check_vec("rst_locked", 32'(locked), 32'h0);
    check_vec("rst_ferr", 32'(frame_err), 32'h0);
    rst_n = 1'b1;

    step(4'h0, 32'h12345678);
    chk_out("hunt_drop", 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      step(4'hF, 32'hBCBCBCBC);
      check_vec("lock_os", 32'(ordered_sets), 32'(OS_IDLE));
      check_vec("lock_locked", 32'(locked), 32'(i == 3));
    end

    step(4'h0, 32'hDEADBEEF);
    chk_out("ml_word", 1'b1, 32'hDEADBEEF, 1'b0);
    step(4'hF, 32'h1C1C1C1C);
    chk_out("ml_cc", 1'b0, 32'h0, 1'b0);
    check_vec("ml_cc_os", 32'(ordered_sets), 32'(OS_CLOCK_COMP));
    step(4'hF, 32'hBCBC1CBC);
    check_vec("ml_kdiff_ferr", 32'(frame_err), 32'h1);
    check_vec("ml_kdiff_os", 32'(ordered_sets), 32'(OS_NONE));
    check_vec("ml_kdiff_locked", 32'(locked), 32'h1);
    step(4'hF, 32'hBCBCBCBC);
    check_vec("ml_idle_ferr", 32'(frame_err), 32'h0);

    single_lane = 1'b1;
    lane_select = 2'd2;
    sl(1'b0, 8'h11); chk_out("sl_b1", 1'b0, 32'h0, 1'b0);
    sl(1'b0, 8'h22); chk_out("sl_b2", 1'b0, 32'h0, 1'b0);
    sl(1'b0, 8'h33); chk_out("sl_b3", 1'b0, 32'h0, 1'b0);
    sl(1'b0, 8'h44); chk_out("sl_w1", 1'b1, 32'h11223344, 1'b0);
    sl(1'b0, 8'h55); chk_out("sl_b5", 1'b0, 32'h0, 1'b0);
    sl(1'b0, 8'h66);
    sl(1'b0, 8'h77);
    sl(1'b0, 8'h88); chk_out("sl_w2", 1'b1, 32'h55667788, 1'b0);

    sl(1'b0, 8'hAA);
    sl(1'b0, 8'hBB); chk_out("part_b2", 1'b0, 32'h0, 1'b0);
    sl(1'b1, 8'hBC); chk_out("part_k", 1'b0, 32'h0, 1'b1);
    check_vec("part_os", 32'(ordered_sets), 32'(OS_IDLE));
    sl(1'b0, 8'h01); chk_out("part_n1", 1'b0, 32'h0, 1'b0);
    sl(1'b0, 8'h02);
    sl(1'b0, 8'h03);
    sl(1'b0, 8'h04); chk_out("part_word", 1'b1, 32'h01020304, 1'b0);

    sl(1'b0, 8'hAA);
    sl(1'b1, 8'h1C); chk_out("cc_k", 1'b0, 32'h0, 1'b0);
    check_vec("cc_os", 32'(ordered_sets), 32'(OS_CLOCK_COMP));
    sl(1'b0, 8'hBB);
    sl(1'b0, 8'hCC); chk_out("cc_b3", 1'b0, 32'h0, 1'b0);
    sl(1'b0, 8'hDD); chk_out("cc_word", 1'b1, 32'hAABBCCDD, 1'b0);

    single_lane = 1'b0;
    step(4'b0101, 32'h0);
    check_vec("inv1_ferr", 32'(frame_err), 32'h1);
    step(4'b0101, 32'h0);
    check_vec("inv2_locked", 32'(locked), 32'h1);
    step(4'hF, 32'hBCBCBCBC);
    check_vec("inv_idle_locked", 32'(locked), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(4'b0101, 32'h0);
      check_vec("unlock_ferr", 32'(frame_err), 32'h1);
      check_vec("unlock_locked", 32'(locked), 32'(i != 2));
    end
    step(4'h0, 32'hCAFEF00D);
    chk_out("unlock_drop", 1'b0, 32'h0, 1'b0);
`ifdef RX_LANE_CTRL_STATS_EN
    check_vec("err_count", 32'(err_count), 32'd7);
`endif

    for (int i = 0; i < 4; i++) step(4'hF, 32'hBCBCBCBC);
    check_vec("relock", 32'(locked), 32'h1);
    single_lane = 1'b1;
    sl(1'b0, 8'h11);
    sl(1'b0, 8'h22);
    rst_n = 1'b0;
    step(4'h0, 32'h0);
    check_vec("mrst_data_out", data_out, 32'h0);
    check_vec("mrst_valid", 32'(data_valid), 32'h0);
    check_vec("mrst_os", 32'(ordered_sets), 32'(OS_NONE));
    check_vec("mrst_locked", 32'(locked), 32'h0);
    check_vec("mrst_ferr", 32'(frame_err), 32'h0);
`ifdef RX_LANE_CTRL_STATS_EN
    check_vec("mrst_err_count", 32'(err_count), 32'h0);
`endif
    rst_n = 1'b1;
    sl(1'b0, 8'h33);
    sl(1'b0, 8'h44); chk_out("post_rst_drop", 1'b0, 32'h0, 1'b0);
    check_vec("post_rst_locked", 32'(locked), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
